addsub_rr_pipe: RTL and testbench



---
 rtl/addsub_rr_pipe.sv | 140 ++++++++++++++
 tb/tb_addsub_rr_pipe.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/addsub_rr_pipe.sv
// addsub_rr_pipe: multi-flux signed add/subtract actor. A round-robin
// arbiter pops one operand pair per cycle from the ready fluxes into a
// one-entry registered output stage. That stage drains to the tagged write
// port and can be refilled in the same cycle it drains.
module addsub_rr_pipe #(
    parameter int FLUX       = 2,
    parameter int DATA_WIDTH = 18,
    parameter int TAG_WIDTH  = $clog2(FLUX),
    parameter bit SUB        = 1'b0,
    parameter bit SATURATE   = 1'b0
) (
    input  logic                            clk,
    input  logic                            rst_n,
    // operand A read port (first-word-fall-through)
    input  logic [FLUX-1:0]                 read_port_opA_empty,
    output logic [FLUX-1:0]                 read_port_opA_read,
    input  logic [DATA_WIDTH+TAG_WIDTH-1:0] read_port_opA_dout,
    // operand B read port (first-word-fall-through)
    input  logic [FLUX-1:0]                 read_port_opB_empty,
    output logic [FLUX-1:0]                 read_port_opB_read,
    input  logic [DATA_WIDTH+TAG_WIDTH-1:0] read_port_opB_dout,
    // result write port
    input  logic [FLUX-1:0]                 write_port_sum_full,
    output logic                            write_port_sum_write,
    output logic [DATA_WIDTH+TAG_WIDTH-1:0] write_port_sum_din,
    output logic                            ovf
);

    localparam int WORD_W = DATA_WIDTH + TAG_WIDTH;

    localparam logic signed [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [TAG_WIDTH-1:0]         LAST_CH = TAG_WIDTH'(FLUX - 1);
    localparam logic [FLUX-1:0]              ONE_HOT = {{(FLUX-1){1'b0}}, 1'b1};

    // Exact result, one guard bit wider than the operands.
    function automatic logic signed [DATA_WIDTH:0] exact_result(
        input logic signed [DATA_WIDTH-1:0] a,
        input logic signed [DATA_WIDTH-1:0] b
    );
        logic signed [DATA_WIDTH:0] ax;
        logic signed [DATA_WIDTH:0] bx;
        ax = {a[DATA_WIDTH-1], a};
        bx = {b[DATA_WIDTH-1], b};
        return SUB ? (ax - bx) : (ax + bx);
    endfunction

    // The exact value left the signed range when the guard bit and the sign bit disagree.
    function automatic logic range_ovf(input logic signed [DATA_WIDTH:0] e);
        return e[DATA_WIDTH] ^ e[DATA_WIDTH-1];
    endfunction

    // Wrap or clamp according to SATURATE; the guard bit gives the true sign.
    function automatic logic signed [DATA_WIDTH-1:0] saturate_result(
        input logic signed [DATA_WIDTH:0] e
    );
        if (SATURATE && range_ovf(e))
            return e[DATA_WIDTH] ? SAT_MIN : SAT_MAX;
        else
            return e[DATA_WIDTH-1:0];
    endfunction

    // Output stage registers and arbiter pointer
    logic                         vld_p1;
    logic [TAG_WIDTH-1:0]         tag_p1;
    logic signed [DATA_WIDTH-1:0] data_p1;
    logic                         ovf_p1;
    logic [TAG_WIDTH-1:0]         ptr;

    logic signed [DATA_WIDTH-1:0] opa_p0;
    logic signed [DATA_WIDTH-1:0] opb_p0;
    logic signed [DATA_WIDTH:0]   exact_p0;
    logic [FLUX-1:0]              eligible;
    logic                         drain;
    logic                         can_load;
    logic                         grant_vld;
    logic [TAG_WIDTH-1:0]         grant_tag;
    logic                         unused_tags;

    // Incoming tag bits carry no meaning for this actor.
    assign unused_tags = ^{read_port_opA_dout[WORD_W-1:DATA_WIDTH],
                           read_port_opB_dout[WORD_W-1:DATA_WIDTH]};

    // ---- stage p0: operand capture and arithmetic ----
    assign opa_p0   = read_port_opA_dout[DATA_WIDTH-1:0];
    assign opb_p0   = read_port_opB_dout[DATA_WIDTH-1:0];
    assign exact_p0 = exact_result(opa_p0, opb_p0);

    assign eligible = ~read_port_opA_empty & ~read_port_opB_empty & ~write_port_sum_full;
    assign drain    = vld_p1 && !write_port_sum_full[tag_p1];
    assign can_load = rst_n && (!vld_p1 || drain);

    // Round-robin scan starting at ptr; first eligible channel wins.
    always_comb begin
        int                   idx;
        logic [TAG_WIDTH-1:0] idx_t;
        grant_vld = 1'b0;
        grant_tag = '0;
        idx       = 0;
        idx_t     = '0;
        for (int k = 0; k < FLUX; k++) begin
            idx = int'(ptr) + k;
            if (idx >= FLUX)
                idx = idx - FLUX;
            idx_t = TAG_WIDTH'(idx);
            if (!grant_vld && can_load && eligible[idx_t]) begin
                grant_vld = 1'b1;
                grant_tag = idx_t;
            end
        end
    end

    assign read_port_opA_read = grant_vld ? (ONE_HOT << grant_tag) : '0;
    assign read_port_opB_read = grant_vld ? (ONE_HOT << grant_tag) : '0;

    // ---- stage p1: registered result, drained to the write port ----
    assign write_port_sum_write = drain;
    assign write_port_sum_din   = {tag_p1, data_p1};
    assign ovf                  = ovf_p1 && drain;

    // Load the stage on a grant (possibly while draining), otherwise empty it on drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1  <= 1'b0;
            tag_p1  <= '0;
            data_p1 <= '0;
            ovf_p1  <= 1'b0;
            ptr     <= '0;
        end else if (grant_vld) begin
            vld_p1  <= 1'b1;
            tag_p1  <= grant_tag;
            data_p1 <= saturate_result(exact_p0);
            ovf_p1  <= range_ovf(exact_p0);
            ptr     <= (grant_tag == LAST_CH) ? '0 : grant_tag + 1'b1;
        end else if (drain) begin
            vld_p1  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_addsub_rr_pipe.sv
// Bench for addsub_rr_pipe: three instances (add/wrap, add/saturate,
// sub/saturate) share one set of FIFO models. The driver arbitrates with a
// round-robin reference and pushes expected results into a scoreboard.
// A separate monitor pops the scoreboard whenever a write is due.
module tb_addsub_rr_pipe;

    localparam int NDUT = 3;
    localparam int MAXV = 131071;
    localparam int MINV = -131072;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [1:0]  a_empty, b_empty, full;
    logic [18:0] a_dout, b_dout;
    logic [1:0]  a_read [NDUT];
    logic [1:0]  b_read [NDUT];
    logic        wr     [NDUT];
    logic [18:0] din    [NDUT];
    logic        ovf_o  [NDUT];

    for (genvar i = 0; i < NDUT; i++) begin : g_dut
        addsub_rr_pipe #(
            .FLUX(2), .DATA_WIDTH(18), .SUB(i == 2), .SATURATE(i >= 1)
        ) u_dut (
            .clk(clk),
            .rst_n(rst_n),
            .read_port_opA_empty(a_empty),
            .read_port_opA_read(a_read[i]),
            .read_port_opA_dout(a_dout),
            .read_port_opB_empty(b_empty),
            .read_port_opB_read(b_read[i]),
            .read_port_opB_dout(b_dout),
            .write_port_sum_full(full),
            .write_port_sum_write(wr[i]),
            .write_port_sum_din(din[i]),
            .ovf(ovf_o[i])
        );
    end

    typedef struct packed {
        logic            tag;
        logic [2:0][17:0] d;
        logic [2:0]      o;
    } exp_t;

    logic signed [17:0] qa [2][$];
    logic signed [17:0] qb [2][$];
    exp_t sb [$];

    int   total = 0;
    int   bad   = 0;
    logic rst_req = 1'b0;
    logic [1:0] full_req = 2'b00;
    int   m_ptr = 0;
    bit   m_valid = 1'b0;
    int   m_tag = 0;
    bit   exp_drain = 1'b0;
    int   exp_g = -1;
    bit   mon_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Spec arithmetic with plain integers: exact value, range test, wrap or clamp.
    function automatic void ref_calc(input int a, input int b, input bit sub, input bit sat,
                                     output logic [17:0] d, output logic o);
        int e;
        e = sub ? a - b : a + b;
        o = (e > MAXV) || (e < MINV);
        if (o && sat) e = (e > 0) ? MAXV : MINV;
        d = e[17:0];
    endfunction

    task automatic push_pair(input int ch, input int a, input int b);
        qa[ch].push_back(18'(a));
        qb[ch].push_back(18'(b));
    endtask

    function automatic int rnd_val();
        case ($urandom_range(0, 3))
            0:       return MAXV;
            1:       return MINV;
            default: return int'($urandom_range(0, 262143)) + MINV;
        endcase
    endfunction

    // One clock cycle: apply inputs, predict the cycle, then check and serve reads.
    task automatic cycle();
        bit elig [2];
        bit can_load;
        logic [1:0] mask;
        logic signed [17:0] av, bv;
        exp_t e;
        @(negedge clk);
        rst_n = rst_req;
        full  = full_req;
        for (int i = 0; i < 2; i++) begin
            a_empty[i] = (qa[i].size() == 0);
            b_empty[i] = (qb[i].size() == 0);
        end
        if (!rst_n) begin
            if (m_valid && sb.size() > 0) void'(sb.pop_back());
            m_valid = 1'b0;
            m_ptr   = 0;
        end
        for (int i = 0; i < 2; i++)
            elig[i] = rst_n && !a_empty[i] && !b_empty[i] && !full[i];
        exp_drain = rst_n && m_valid && !full[m_tag];
        can_load  = rst_n && (!m_valid || exp_drain);
        exp_g = -1;
        if (can_load)
            for (int k = 0; k < 2; k++)
                if (exp_g < 0 && elig[(m_ptr + k) % 2]) exp_g = (m_ptr + k) % 2;
        #2;
        mask = (exp_g >= 0) ? 2'(1 << exp_g) : 2'b00;
        for (int i = 0; i < NDUT; i++) begin
            check($sformatf("readA_dut%0d", i), a_read[i], mask);
            check($sformatf("readB_dut%0d", i), b_read[i], mask);
        end
        if (exp_g >= 0) begin
            av = qa[exp_g].pop_front();
            bv = qb[exp_g].pop_front();
            a_dout = {1'($urandom()), av};
            b_dout = {1'($urandom()), bv};
            e.tag = 1'(exp_g);
            for (int i = 0; i < NDUT; i++)
                ref_calc(int'(av), int'(bv), i == 2, i >= 1, e.d[i], e.o[i]);
            sb.push_back(e);
            m_valid = 1'b1;
            m_tag   = exp_g;
            m_ptr   = (exp_g + 1) % 2;
        end else if (exp_drain) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    // Monitor: compare write strobes and pop the scoreboard on every due write.
    always @(negedge clk) begin
        exp_t e;
        #1;
        if (mon_en) begin
            for (int i = 0; i < NDUT; i++) begin
                check($sformatf("write_dut%0d", i), wr[i], exp_drain);
                if (!exp_drain) check($sformatf("ovf_idle_dut%0d", i), ovf_o[i], 1'b0);
                if (!rst_n) check($sformatf("din_reset_dut%0d", i), din[i], 19'd0);
            end
            if (exp_drain) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL scoreboard_empty actual=write required=no_write");
                end else begin
                    e = sb.pop_front();
                    for (int i = 0; i < NDUT; i++) begin
                        check($sformatf("din_dut%0d", i), din[i], {e.tag, e.d[i]});
                        check($sformatf("ovf_dut%0d", i), ovf_o[i], e.o[i]);
                    end
                end
            end
        end
    end

    initial begin
        logic [18:0] held;
        rst_n = 1'b0; full = 2'b00; a_empty = 2'b11; b_empty = 2'b11;
        a_dout = '0; b_dout = '0;
        mon_en = 1'b1;

        // Reset with all FIFOs non-empty, then release: channel 0 first.
        push_pair(0, 5, 6); push_pair(1, 7, 8);
        push_pair(0, -9, 4); push_pair(1, 11, -12);
        rst_req = 1'b0;
        run(3);
        rst_req = 1'b1;
        cycle();
        check("first_grant_after_reset", a_read[0], 2'b01);
        run(8);

        // Basic add on channel 1 only.
        push_pair(1, 100, -30);
        cycle();
        check("basic_read_ch1", a_read[0], 2'b10);
        cycle();
        check("basic_din", din[0], {1'b1, 18'd70});
        run(2);

        // Round-robin with both channels continuously ready.
        for (int i = 0; i < 6; i++) begin
            push_pair(0, rnd_val(), rnd_val());
            push_pair(1, rnd_val(), rnd_val());
        end
        run(14);

        // Overflow corners.
        push_pair(0, MAXV, 1);
        push_pair(0, MINV, 1);
        run(6);

        // Backpressure: staged tag 0 held by full[0] while channel 1 waits.
        push_pair(0, 1234, 4321);
        cycle();
        full_req = 2'b01;
        push_pair(1, -50, 20); push_pair(1, 3, 3);
        cycle();
        held = din[0];
        for (int i = 0; i < 2; i++) begin
            cycle();
            check("held_din_stable", din[0], held);
        end
        full_req = 2'b00;
        cycle();
        check("drain_and_grant_ch1", a_read[0], 2'b10);
        run(4);

        // Asymmetric empties: ch0 has A only.
        qa[0].push_back(18'sd77); qa[0].push_back(-18'sd5);
        for (int i = 0; i < 3; i++) push_pair(1, rnd_val(), rnd_val());
        run(6);
        qb[0].push_back(18'sd3); qb[0].push_back(18'sd10);
        run(6);

        // Randomised traffic with random backpressure.
        for (int c = 0; c < 400; c++) begin
            for (int ch = 0; ch < 2; ch++) begin
                if (qa[ch].size() < 6 && $urandom_range(0, 2) != 0) qa[ch].push_back(18'(rnd_val()));
                if (qb[ch].size() < 6 && $urandom_range(0, 2) != 0) qb[ch].push_back(18'(rnd_val()));
            end
            full_req = ($urandom_range(0, 3) == 0) ? 2'($urandom()) : 2'b00;
            cycle();
        end
        full_req = 2'b00;
        run(20);

        // Reset mid-operation discards the staged result.
        for (int i = 0; i < 3; i++) begin
            push_pair(0, rnd_val(), rnd_val());
            push_pair(1, rnd_val(), rnd_val());
        end
        run(2);
        rst_req = 1'b0;
        run(2);
        rst_req = 1'b1;
        run(12);

        // Pair up any leftover singles and drain everything.
        for (int ch = 0; ch < 2; ch++) begin
            while (qa[ch].size() < qb[ch].size()) qa[ch].push_back(18'sd1);
            while (qb[ch].size() < qa[ch].size()) qb[ch].push_back(18'sd1);
        end
        run(30);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        check("final_idle_write", wr[0], 1'b0);

        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
